fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC/address width.
REQ-002 SHALL have parameter DEPTH, default 4: instruction-buffer entries; power of 2, >=2.
REQ-003 SHALL have parameter RESET_PC, default 0: first fetch address.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-007 SHALL have port imem_req_addr  output  XLEN  fetch byte address, word aligned.
REQ-008 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-009 SHALL have port imem_rsp_valid  input  1  in-order response valid, >=1 cycle after acceptance.
REQ-010 SHALL have port imem_rsp_data  input  32  fetched instruction.
REQ-011 SHALL have port redirect_valid  input  1  branch/jump taken, flush.
REQ-012 SHALL have port redirect_pc  input  XLEN  new fetch target.
REQ-013 SHALL have port dec_valid  output  1  instruction available to decode.
REQ-014 SHALL have port dec_instr  output  32  head instruction.
REQ-015 SHALL have port dec_pc_plus4  output  XLEN  head instruction address + 4.
REQ-016 SHALL have port dec_ready  input  1  decode consumes head.
REQ-017 SHALL have port occupancy  output  clog2(DEPTH)+1  buffered entries.

Function
REQ-018 Handshakes SHALL complete when valid && ready on a rising edge; valid and payload held stable until then.
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN; IDLE -> RUN unconditionally one cycle after reset release.
REQ-020 In RUN, imem_req_valid SHALL be 1 iff occupancy + outstanding < DEPTH and redirect_valid = 0.
REQ-021 Each accepted request SHALL advance fetch PC by 4, wrapping modulo 2^XLEN; outstanding += 1.
REQ-022 Each response in RUN SHALL be written to the buffer tagged with rsp_pc + 4; rsp_pc += 4; outstanding -= 1.
REQ-023 Buffer SHALL be FIFO; dec_valid = (occupancy != 0); combined-latency fetch-to-decode minimum 2 cycles (response registered).
REQ-024 Simultaneous write and pop SHALL leave occupancy unchanged; pop when empty and write when full SHALL not occur by construction (REQ-020).
REQ-025 On redirect_valid: next edge buffer cleared, fetch PC and rsp_pc <= redirect_pc, drop count <= outstanding (including any response this cycle, which is discarded); enter DRAIN if drop count > 0, else stay RUN.
REQ-026 Decode handshake coincident with redirect SHALL complete; buffer still flushed.
REQ-027 In DRAIN: no requests; each response discarded and decrements drop count; at zero -> RUN.
REQ-028 Redirect in DRAIN SHALL update fetch PC/rsp_pc only; drop count unchanged.
REQ-029 imem_req_addr SHALL always equal fetch PC; redirect_pc low 2 bits SHALL be forced to 0.

Reset
REQ-030 Reset SHALL set state IDLE, fetch PC = rsp_pc = RESET_PC, outstanding = drop = occupancy = 0, imem_req_valid = 0, dec_valid = 0, dec_instr = 0, dec_pc_plus4 = 0.
REQ-031 Reset mid-operation SHALL abandon outstanding requests; memory-side responses after reset release but before the first new request are a system error, not handled.

Configuration
REQ-032 Macro FETCH_PERF_CNT_EN defined: SHALL add outputs perf_flush_cnt (32) counting redirects and perf_empty_cnt (32) counting cycles dec_ready=1 && dec_valid=0; both reset to 0, wrap at 2^32.
REQ-033 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-034 Package fetch_pkg SHALL hold the FSM state enum, INSTR_W = 32, and NOP instruction constant 32'h0000_0000.
REQ-035 Buffer SHALL be sub-module fetch_fifo (parameters WIDTH, DEPTH; push, pop, flush, occupancy).

Verification
REQ-036 Reset release, RESET_PC=0, ready=1, 1-cycle memory -> requests at 0,4,8,12; dec_pc_plus4 sequence 4,8,12,16.
REQ-037 dec_ready=0, DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0, occupancy=4 held.
REQ-038 Redirect to 0x40 with 2 outstanding -> DRAIN, 2 responses dropped, next request 0x40, first dec_pc_plus4 0x44.
REQ-039 Redirect to 0x3 while dec handshake fires -> handshake completes, buffer empty next cycle, request address 0x0.
REQ-040 Fetch PC 0xFFFF_FFFC, XLEN=32 -> next request 0x0000_0000, dec_pc_plus4 0x0000_0000.
REQ-041 FETCH_PERF_CNT_EN defined, 3 redirects and 5 starved cycles -> perf_flush_cnt=3, perf_empty_cnt=5.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-2 circular FIFO with synchronous flush.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_dat_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       head_dat_o,
    output logic [$clog2(DEPTH):0] occupancy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // Pointer and count update; flush wins over a coincident push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Entry storage; cleared at reset so the head reads zero before any write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_dat_o  = mem_q[rd_ptr_q];
    assign occupancy_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word fetches, buffers responses, handles redirect/drain. Optional perf counters under FETCH_PERF_CNT_EN.
// Latency: response registered into the buffer, so fetch-to-decode is at least 2 cycles.
// Backpressure: requests stall when buffered + outstanding reaches DEPTH; decode stalls via dec_ready.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req_valid,
    output logic [XLEN-1:0]        imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_W-1:0]     imem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   dec_valid,
    output logic [INSTR_W-1:0]     dec_instr,
    output logic [XLEN-1:0]        dec_pc_plus4,
    input  logic                   dec_ready,
    output logic [$clog2(DEPTH):0] occupancy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            perf_flush_cnt,
    output logic [31:0]            perf_empty_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = INSTR_W + XLEN;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic            req_vld;
    logic            push;
    logic            pop;
    logic            flush;
    logic [EW-1:0]   push_dat;
    logic [EW-1:0]   head_dat;
    logic [CW-1:0]   occ;
    logic [CW:0]     inflight;
    logic [XLEN-1:0] redir_pc;

    assign redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
    assign inflight = {1'b0, occ} + {1'b0, outst_q};
    assign push_dat = {imem_rsp_data, rsp_pc_q + XLEN'(4)};
    assign pop      = dec_valid && dec_ready;

    // State and fetch bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    // Next-state, request issue and buffer write/flush decisions.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        req_vld    = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = RUN;
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc;
                    rsp_pc_d   = redir_pc;
                end
            end
            RUN: begin
                req_vld = (inflight < DEPTH_C) && !redirect_valid;
                if (redirect_valid) begin
                    // A response landing this cycle belongs to the old path and is
                    // discarded here, so it no longer needs dropping later.
                    flush      = 1'b1;
                    fetch_pc_d = redir_pc;
                    rsp_pc_d   = redir_pc;
                    outst_d    = outst_q - CW'(imem_rsp_valid);
                    drop_d     = outst_d;
                    state_d    = (outst_d != '0) ? DRAIN : RUN;
                end else begin
                    if (req_vld && imem_req_ready) begin
                        fetch_pc_d = fetch_pc_q + XLEN'(4);
                    end
                    if (imem_rsp_valid) begin
                        push     = 1'b1;
                        rsp_pc_d = rsp_pc_q + XLEN'(4);
                    end
                    outst_d = outst_q + CW'(req_vld && imem_req_ready) - CW'(imem_rsp_valid);
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    drop_d  = drop_q - CW'(1);
                    outst_d = outst_q - CW'(1);
                end
                if (drop_d == '0) begin
                    state_d = RUN;
                end
                // A further redirect only retargets; the stale responses still in
                // flight are already counted.
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc;
                    rsp_pc_d   = redir_pc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    fetch_fifo #(
        .WIDTH(EW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .flush_i    (flush),
        .head_dat_o (head_dat),
        .occupancy_o(occ)
    );

    assign imem_req_valid = req_vld;
    assign imem_req_addr  = fetch_pc_q;
    assign occupancy      = occ;
    assign dec_valid      = (occ != '0);
    assign dec_instr      = dec_valid ? head_dat[EW-1:XLEN] : NOP_INSTR;
    assign dec_pc_plus4   = dec_valid ? head_dat[XLEN-1:0] : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] flush_cnt_q;
    logic [31:0] empty_cnt_q;

    // Count redirects and cycles where decode wanted an instruction but none was buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_q <= '0;
            empty_cnt_q <= '0;
        end else begin
            if (redirect_valid) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
            if (dec_ready && !dec_valid) begin
                empty_cnt_q <= empty_cnt_q + 32'd1;
            end
        end
    end

    assign perf_flush_cnt = flush_cnt_q;
    assign perf_empty_cnt = empty_cnt_q;
`endif

endmodule
